// File: rtl/ro_adder_tree_pipe_if.sv
// Purpose: bundles the sample-in / tree-out / window-out signals of ro_adder_tree_pipe.
// Latency: none (wires only).
// Backpressure: none; the producer may present a sample every cycle.
// Ports: in_flat/in_valid/acc_len/acc_clear (producer -> tree), tree_sum/tree_valid,
//        acc_sum/acc_valid/acc_busy (tree -> consumer). ch_mask exists only when
//        RO_TREE_CH_MASK_EN is defined.
interface ro_adder_tree_pipe_if #(
    parameter int NUM_IN  = 16,
    parameter int IN_W    = 32,
    parameter int ACC_EXT = 8
);
    localparam int LVL   = $clog2(NUM_IN);
    localparam int OUT_W = IN_W + LVL;
    localparam int ACC_W = OUT_W + ACC_EXT;

    logic [NUM_IN*IN_W-1:0] in_flat;
    logic                   in_valid;
    logic [ACC_EXT-1:0]     acc_len;
    logic                   acc_clear;
`ifdef RO_TREE_CH_MASK_EN
    logic [NUM_IN-1:0]      ch_mask;
`endif
    logic [OUT_W-1:0]       tree_sum;
    logic                   tree_valid;
    logic [ACC_W-1:0]       acc_sum;
    logic                   acc_valid;
    logic                   acc_busy;

    modport master (
`ifdef RO_TREE_CH_MASK_EN
        output ch_mask,
`endif
        output in_flat, in_valid, acc_len, acc_clear,
        input  tree_sum, tree_valid, acc_sum, acc_valid, acc_busy
    );

    modport slave (
`ifdef RO_TREE_CH_MASK_EN
        input  ch_mask,
`endif
        input  in_flat, in_valid, acc_len, acc_clear,
        output tree_sum, tree_valid, acc_sum, acc_valid, acc_busy
    );
endinterface

// File: rtl/ro_adder_tree_pipe.sv
// Purpose: pipelined adder tree over NUM_IN ring-oscillator counts plus a window accumulator.
// Latency: tree_sum LVL cycles after in_flat; acc_sum one cycle after the closing tree_valid.
// Backpressure: none; one sample per cycle, never stalls.
// Ports: clk, rst_n (synchronous, active-low), bus (ro_adder_tree_pipe_if.slave).
// Optional: define RO_TREE_CH_MASK_EN to add bus.ch_mask, zeroing channels before level 1.
module ro_adder_tree_pipe #(
    parameter int NUM_IN  = 16,
    parameter int IN_W    = 32,
    parameter int ACC_EXT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ro_adder_tree_pipe_if.slave   bus
);
    localparam int LVL   = $clog2(NUM_IN);
    localparam int OUT_W = IN_W + LVL;
    localparam int ACC_W = OUT_W + ACC_EXT;

    // Level j holds NUM_IN>>j partial sums of IN_W+j bits, packed flat.
    // Level 0 is the (optionally masked) input itself, not a register.
    for (genvar j = 0; j <= LVL; j++) begin : g_lvl
        localparam int N = NUM_IN >> j;
        localparam int W = IN_W + j;

        logic [N*W-1:0] dat;
        logic           vld;

        if (j == 0) begin : g_src
`ifdef RO_TREE_CH_MASK_EN
            // Masking here means the mask is captured with the sample it applies to.
            for (genvar k = 0; k < NUM_IN; k++) begin : g_ch
                assign dat[k*IN_W +: IN_W] = bus.in_flat[k*IN_W +: IN_W] & {IN_W{bus.ch_mask[k]}};
            end
`else
            assign dat = bus.in_flat;
`endif
            assign vld = bus.in_valid;
        end else begin : g_add
            localparam int PW = W - 1;
            // Data loads every cycle; only vld qualifies it downstream.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dat <= '0;
                    vld <= 1'b0;
                end else begin
                    vld <= g_lvl[j-1].vld;
                    for (int k = 0; k < N; k++) begin
                        dat[k*W +: W] <= {1'b0, g_lvl[j-1].dat[(2*k)*PW +: PW]}
                                       + {1'b0, g_lvl[j-1].dat[(2*k+1)*PW +: PW]};
                    end
                end
            end
        end
    end

    assign bus.tree_sum   = g_lvl[LVL].dat;
    assign bus.tree_valid = g_lvl[LVL].vld;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    localparam logic [ACC_EXT-1:0] ONE = {{(ACC_EXT-1){1'b0}}, 1'b1};

    state_t             state;
    logic [ACC_EXT-1:0] count;
    logic [ACC_EXT-1:0] eff_len;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum_q;
    logic               acc_valid_q;

    logic [ACC_W-1:0]   tree_ext;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_EXT-1:0] count_inc;
    logic [ACC_EXT-1:0] len_now;

    assign tree_ext  = {{ACC_EXT{1'b0}}, bus.tree_sum};
    assign acc_next  = acc + tree_ext;
    assign count_inc = count + ONE;
    // A length of 0 is treated as 1 so every sample closes its own window.
    assign len_now   = (bus.acc_len == '0) ? ONE : bus.acc_len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            eff_len     <= '0;
            acc         <= '0;
            acc_sum_q   <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;
            if (bus.acc_clear) begin
                // Abort wins over a coincident sample, which is dropped.
                state <= S_IDLE;
                count <= '0;
            end else if (bus.tree_valid) begin
                case (state)
                    S_IDLE: begin
                        eff_len <= len_now;
                        acc     <= tree_ext;
                        if (len_now == ONE) begin
                            acc_sum_q   <= tree_ext;
                            acc_valid_q <= 1'b1;
                        end else begin
                            count <= ONE;
                            state <= S_ACCUM;
                        end
                    end
                    S_ACCUM: begin
                        if (count_inc == eff_len) begin
                            acc_sum_q   <= acc_next;
                            acc_valid_q <= 1'b1;
                            count       <= '0;
                            state       <= S_IDLE;
                        end else begin
                            acc   <= acc_next;
                            count <= count_inc;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.acc_sum   = acc_sum_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.acc_busy  = (count != '0);
endmodule
